// File: rtl/hazard_forward_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_forward_ctrl_if
//   Bundles the ID-side request signals and the controller's responses
//   between the pipeline and hazard_forward_ctrl.
//
//   Handshake: there is no valid/ready pair. id_valid_i qualifies the ID
//   fields in the same cycle. stall_o is the combinational back-pressure
//   for that instruction: while it is 1 the pipeline holds PC and IF/ID, and
//   the controller inserts a bubble into EX. flush_i kills the ID
//   instruction and wins over stall_o.
//
//   Signals (directions seen from the controller, i.e. the slave modport):
//     flush_i       in   kill ID instruction
//     id_valid_i    in   ID holds a real instruction
//     id_src_vld_i  in   per-operand "source is read" flag
//     id_src_i      in   packed source registers, operand s at [s*REG_AW +: REG_AW]
//     id_regw_i     in   ID instruction writes rd
//     id_load_i     in   ID instruction is a load
//     id_rd_i       in   ID destination register
//     stall_o       out  load-use stall for ID
//     ex_valid_o    out  EX slot holds a real instruction
//     fwd_sel_o     out  per EX operand bypass select, SELW bits each
// ----------------------------------------------------------------------------
interface hazard_forward_ctrl_if #(
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2
);
    localparam int SELW = $clog2(FWD_DEPTH + 1);

    logic                      flush_i;
    logic                      id_valid_i;
    logic [NUM_SRC-1:0]        id_src_vld_i;
    logic [NUM_SRC*REG_AW-1:0] id_src_i;
    logic                      id_regw_i;
    logic                      id_load_i;
    logic [REG_AW-1:0]         id_rd_i;
    logic                      stall_o;
    logic                      ex_valid_o;
    logic [NUM_SRC*SELW-1:0]   fwd_sel_o;

    // Pipeline side: drives the ID instruction, consumes stall and selects.
    modport master (
        output flush_i, id_valid_i, id_src_vld_i, id_src_i,
               id_regw_i, id_load_i, id_rd_i,
        input  stall_o, ex_valid_o, fwd_sel_o
    );

    // Controller side.
    modport slave (
        input  flush_i, id_valid_i, id_src_vld_i, id_src_i,
               id_regw_i, id_load_i, id_rd_i,
        output stall_o, ex_valid_o, fwd_sel_o
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_forward_ctrl
//   Forwarding and load-use hazard controller. A shadow pipeline of slots
//   0..FWD_DEPTH (slot 0 = EX) records each in-flight instruction's
//   {vld, regw, load, rd}. Slot 0 also keeps the EX operand sources. From
//   this state the block drives per-operand bypass selects for EX, and a
//   load-use stall for the ID instruction.
//
//   Ports:
//     clk_i        clock, rising edge
//     rst_i        synchronous active-high reset; drops all tracking
//     bus          hazard_forward_ctrl_if.slave (ID request, stall/select out)
//     stall_cnt_o  [HAZ_PERF_CNT_EN only] cycles with stall_o = 1
//     fwd_cnt_o    [HAZ_PERF_CNT_EN only] valid EX cycles with any select != 0
//
//   Optional build macro: HAZ_PERF_CNT_EN adds the two wrapping 32-bit
//   performance counters. Without it the counters and ports are absent.
//
//   The data of a load is forwardable from stage 1+LOAD_LAT. For a
//   load-use pair to resolve through the bypass, 1+LOAD_LAT <= FWD_DEPTH
//   must hold. If it does not, the consumer reads the regfile after the stall.
// ----------------------------------------------------------------------------
module hazard_forward_ctrl #(
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    hazard_forward_ctrl_if.slave bus
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt_o,
    output logic [31:0]          fwd_cnt_o
`endif
);
    localparam int SELW = $clog2(FWD_DEPTH + 1);

    // Shadow pipeline. Bit/entry k is slot k.
    logic [FWD_DEPTH:0]        vld_q;
    logic [FWD_DEPTH:0]        regw_q;
    logic [FWD_DEPTH:0]        load_q;
    logic [REG_AW-1:0]         rd_q [FWD_DEPTH+1];
    logic [NUM_SRC-1:0]        src_vld_q;
    logic [NUM_SRC*REG_AW-1:0] src_q;

    logic                      stall;
    logic                      capture;
    logic                      hit;
    logic [NUM_SRC*SELW-1:0]   fwd_sel;

    function automatic logic writer_match(
        input logic              w_vld,
        input logic              w_regw,
        input logic [REG_AW-1:0] w_rd,
        input logic [REG_AW-1:0] src,
        input logic              src_vld
    );
        return w_vld & w_regw & (w_rd != '0) & (w_rd == src) & src_vld;
    endfunction

    // Load-use stall: an ID operand depends on a load whose data is not yet
    // forwardable when the consumer would reach EX next cycle.
    always_comb begin
        stall = 1'b0;
        for (int j = 0; j <= FWD_DEPTH; j++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if ((j < LOAD_LAT) && load_q[j] &&
                    writer_match(vld_q[j], regw_q[j], rd_q[j],
                                 bus.id_src_i[s*REG_AW +: REG_AW],
                                 bus.id_src_vld_i[s])) begin
                    stall = 1'b1;
                end
            end
        end
        // A flushed or empty ID slot has no hazard.
        stall = stall & bus.id_valid_i & ~bus.flush_i;
    end

    // Bypass select. The youngest matching writer decides. If that writer
    // is a load whose data is not ready yet, the select stays 0 and does not
    // fall back to an older writer.
    always_comb begin
        fwd_sel = '0;
        hit     = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            hit = 1'b0;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                if (!hit && writer_match(vld_q[k], regw_q[k], rd_q[k],
                                         src_q[s*REG_AW +: REG_AW],
                                         src_vld_q[s])) begin
                    hit = 1'b1;
                    if (!load_q[k] || (k >= 1 + LOAD_LAT)) begin
                        fwd_sel[s*SELW +: SELW] = SELW'(k);
                    end
                end
            end
        end
    end

    assign capture = bus.id_valid_i & ~stall & ~bus.flush_i;

    // A bubble enters slot 0 with all fields cleared. This keeps it from
    // ever matching or producing a select.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q     <= '0;
            regw_q    <= '0;
            load_q    <= '0;
            src_vld_q <= '0;
            src_q     <= '0;
            for (int k = 0; k <= FWD_DEPTH; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            vld_q     <= {vld_q[FWD_DEPTH-1:0],  capture};
            regw_q    <= {regw_q[FWD_DEPTH-1:0], capture & bus.id_regw_i};
            load_q    <= {load_q[FWD_DEPTH-1:0], capture & bus.id_load_i};
            rd_q[0]   <= capture ? bus.id_rd_i : '0;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                rd_q[k] <= rd_q[k-1];
            end
            src_vld_q <= capture ? bus.id_src_vld_i : '0;
            src_q     <= capture ? bus.id_src_i : '0;
        end
    end

    assign bus.stall_o    = stall;
    assign bus.ex_valid_o = vld_q[0];
    assign bus.fwd_sel_o  = fwd_sel;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (vld_q[0] && (fwd_sel != '0)) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
`timescale 1ns/1ps
module tb_hazard_forward_ctrl;

    // One instruction as the reference model sees it. src holds operand 0 in
    // [4:0] and operand 1 in [9:5].
    typedef struct packed {
        logic       vld;
        logic       regw;
        logic       load;
        logic [4:0] rd;
        logic [1:0] sv;
        logic [9:0] src;
    } ins_t;

    localparam int DEPTH_A = 2;
    localparam int LAT_A   = 1;
    localparam int DEPTH_B = 3;
    localparam int LAT_B   = 2;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   known  = 0;

    // Model history: entry i is the instruction that entered EX i cycles ago.
    ins_t hist_a[$];
    ins_t hist_b[$];

    logic       obs_stall_a, obs_ex_a, obs_stall_b, obs_ex_b;
    logic [3:0] obs_sel_a, obs_sel_b;

    ins_t nop_i;

    hazard_forward_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(DEPTH_A)) if_a ();
    hazard_forward_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(DEPTH_B)) if_b ();

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_a, fwd_cnt_a, stall_cnt_b, fwd_cnt_b;
    logic [31:0] exp_sc_a = 0;
    logic [31:0] exp_fc_a = 0;
`endif

    hazard_forward_ctrl #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(DEPTH_A), .LOAD_LAT(LAT_A)) u_dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_a)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_a),
        .fwd_cnt_o   (fwd_cnt_a)
`endif
    );

    hazard_forward_ctrl #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(DEPTH_B), .LOAD_LAT(LAT_B)) u_dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_b)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_b),
        .fwd_cnt_o   (fwd_cnt_b)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b1;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit writes(ins_t w, ins_t r, int s);
        logic [4:0] sreg;
        sreg = r.src[s*5 +: 5];
        return w.vld && w.regw && (w.rd != 5'd0) && (w.rd == sreg) && r.sv[s];
    endfunction

    // The ID instruction must wait while it reads a load younger than LAT cycles.
    function automatic bit exp_stall(ins_t h[$], int lat, ins_t id, bit flush);
        if (!id.vld || flush) return 1'b0;
        for (int j = 0; j < lat && j < h.size(); j++)
            for (int s = 0; s < 2; s++)
                if (h[j].load && writes(h[j], id, s)) return 1'b1;
        return 1'b0;
    endfunction

    // Youngest earlier writer of each EX operand. A not-yet-ready load gives 0.
    function automatic logic [3:0] exp_sel(ins_t h[$], int depth, int lat);
        logic [3:0] r;
        r = '0;
        for (int s = 0; s < 2; s++) begin
            for (int k = 1; k <= depth; k++) begin
                if (writes(h[k], h[0], s)) begin
                    if (!h[k].load || k >= 1 + lat) r[s*2 +: 2] = 2'(k);
                    break;
                end
            end
        end
        return r;
    endfunction

    function automatic ins_t mk(bit regw, bit load, int rd, int s0, int s1, bit [1:0] sv);
        ins_t n;
        n.vld  = 1'b1;
        n.regw = regw;
        n.load = load;
        n.rd   = 5'(rd);
        n.sv   = sv;
        n.src  = {5'(s1), 5'(s0)};
        return n;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t n;
        n.vld  = ($urandom_range(0, 3) != 0);
        n.regw = 1'($urandom_range(0, 1));
        n.load = ($urandom_range(0, 2) == 0);
        n.rd   = 5'($urandom_range(0, 7));
        n.sv   = 2'($urandom_range(0, 3));
        n.src  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        return n;
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cyc(input ins_t id, input bit flush, input bit r);
        bit         sa, sb;
        logic [3:0] ea, eb;
        ins_t       na, nb;
        rst               = r;
        if_a.flush_i      = flush;         if_b.flush_i      = flush;
        if_a.id_valid_i   = id.vld;        if_b.id_valid_i   = id.vld;
        if_a.id_src_vld_i = id.sv;         if_b.id_src_vld_i = id.sv;
        if_a.id_src_i     = id.src;        if_b.id_src_i     = id.src;
        if_a.id_regw_i    = id.regw;       if_b.id_regw_i    = id.regw;
        if_a.id_load_i    = id.load;       if_b.id_load_i    = id.load;
        if_a.id_rd_i      = id.rd;         if_b.id_rd_i      = id.rd;
        @(negedge clk);
        obs_stall_a = if_a.stall_o;  obs_ex_a = if_a.ex_valid_o;  obs_sel_a = if_a.fwd_sel_o;
        obs_stall_b = if_b.stall_o;  obs_ex_b = if_b.ex_valid_o;  obs_sel_b = if_b.fwd_sel_o;
        sa = exp_stall(hist_a, LAT_A, id, flush);
        sb = exp_stall(hist_b, LAT_B, id, flush);
        ea = exp_sel(hist_a, DEPTH_A, LAT_A);
        eb = exp_sel(hist_b, DEPTH_B, LAT_B);
        if (known) begin
            chk("a_stall", obs_stall_a, sa);
            chk("a_ex_valid", obs_ex_a, hist_a[0].vld);
            chk("a_fwd_sel", obs_sel_a, ea);
            chk("b_stall", obs_stall_b, sb);
            chk("b_ex_valid", obs_ex_b, hist_b[0].vld);
            chk("b_fwd_sel", obs_sel_b, eb);
`ifdef HAZ_PERF_CNT_EN
            chk("a_stall_cnt", stall_cnt_a, exp_sc_a);
            chk("a_fwd_cnt", fwd_cnt_a, exp_fc_a);
`endif
        end
        @(posedge clk);
        if (r) begin
            hist_a = {};
            hist_b = {};
            for (int k = 0; k <= DEPTH_A; k++) hist_a.push_back(nop_i);
            for (int k = 0; k <= DEPTH_B; k++) hist_b.push_back(nop_i);
            known = 1'b1;
`ifdef HAZ_PERF_CNT_EN
            exp_sc_a = 0;
            exp_fc_a = 0;
`endif
        end else begin
`ifdef HAZ_PERF_CNT_EN
            if (sa) exp_sc_a = exp_sc_a + 1;
            if (hist_a[0].vld && ea != 0) exp_fc_a = exp_fc_a + 1;
`endif
            na = (id.vld && !sa && !flush) ? id : nop_i;
            nb = (id.vld && !sb && !flush) ? id : nop_i;
            hist_a.push_front(na);
            void'(hist_a.pop_back());
            hist_b.push_front(nb);
            void'(hist_b.pop_back());
        end
        #1;
    endtask

    task automatic drain();
        repeat (4) cyc(nop_i, 1'b0, 1'b0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        nop_i = '0;
        for (int k = 0; k <= DEPTH_A; k++) hist_a.push_back(nop_i);
        for (int k = 0; k <= DEPTH_B; k++) hist_b.push_back(nop_i);

        // Reset for two cycles with random inputs.
        for (int i = 0; i < 2; i++) cyc(rnd_ins(), 1'($urandom_range(0, 1)), 1'b1);
        cyc(nop_i, 1'b0, 1'b0);
        chk("rst_stall", obs_stall_a, 0);
        chk("rst_ex_valid", obs_ex_a, 0);
        chk("rst_fwd_sel", obs_sel_a, 0);

        // Back-to-back dependence: select stage 1.
        cyc(mk(1, 0, 3, 1, 2, 2'b11), 1'b0, 1'b0);
        cyc(mk(1, 0, 4, 3, 0, 2'b01), 1'b0, 1'b0);
        cyc(nop_i, 1'b0, 1'b0);
        chk("fwd_stage1", obs_sel_a[1:0], 1);
        drain();

        // One unrelated instruction in between: select stage 2.
        cyc(mk(1, 0, 3, 1, 2, 2'b11), 1'b0, 1'b0);
        cyc(mk(1, 0, 7, 1, 2, 2'b11), 1'b0, 1'b0);
        cyc(mk(1, 0, 4, 3, 0, 2'b01), 1'b0, 1'b0);
        cyc(nop_i, 1'b0, 1'b0);
        chk("fwd_stage2", obs_sel_a[1:0], 2);
        chk("fwd_stage2_b", obs_sel_b[1:0], 2);
        drain();

        // r3 written in slots 1 and 2: youngest wins.
        cyc(mk(1, 0, 3, 1, 2, 2'b11), 1'b0, 1'b0);
        cyc(mk(1, 0, 3, 1, 2, 2'b11), 1'b0, 1'b0);
        cyc(mk(1, 0, 4, 3, 0, 2'b01), 1'b0, 1'b0);
        cyc(nop_i, 1'b0, 1'b0);
        chk("youngest_wins", obs_sel_a[1:0], 1);
        drain();

        // Writer to r0 never forwards.
        cyc(mk(1, 0, 0, 1, 2, 2'b11), 1'b0, 1'b0);
        cyc(mk(1, 0, 4, 0, 0, 2'b01), 1'b0, 1'b0);
        cyc(nop_i, 1'b0, 1'b0);
        chk("rd0_no_fwd", obs_sel_a, 0);
        drain();

        // Load-use, LOAD_LAT = 1 (dut a): one stall cycle, then forward from stage 2.
        cyc(mk(1, 1, 5, 1, 0, 2'b01), 1'b0, 1'b0);
        cyc(mk(1, 0, 6, 2, 5, 2'b11), 1'b0, 1'b0);
        chk("lu1_stall", obs_stall_a, 1);
        cyc(mk(1, 0, 6, 2, 5, 2'b11), 1'b0, 1'b0);
        chk("lu1_bubble", obs_ex_a, 0);
        chk("lu1_released", obs_stall_a, 0);
        cyc(nop_i, 1'b0, 1'b0);
        chk("lu1_ex_valid", obs_ex_a, 1);
        chk("lu1_fwd", obs_sel_a[3:2], 2);
        drain();

        // Load-use, LOAD_LAT = 2 (dut b): two stall cycles, then forward from stage 3.
        cyc(mk(1, 1, 5, 1, 0, 2'b01), 1'b0, 1'b0);
        cyc(mk(1, 0, 6, 2, 5, 2'b11), 1'b0, 1'b0);
        chk("lu2_stall1", obs_stall_b, 1);
        cyc(mk(1, 0, 6, 2, 5, 2'b11), 1'b0, 1'b0);
        chk("lu2_stall2", obs_stall_b, 1);
        cyc(mk(1, 0, 6, 2, 5, 2'b11), 1'b0, 1'b0);
        chk("lu2_released", obs_stall_b, 0);
        cyc(nop_i, 1'b0, 1'b0);
        chk("lu2_fwd", obs_sel_b[3:2], 3);
        drain();

        // Flush wins over a pending load-use stall.
        cyc(mk(1, 1, 5, 1, 0, 2'b01), 1'b0, 1'b0);
        cyc(mk(1, 0, 6, 2, 5, 2'b11), 1'b1, 1'b0);
        chk("flush_no_stall", obs_stall_a, 0);
        cyc(nop_i, 1'b0, 1'b0);
        chk("flush_bubble", obs_ex_a, 0);
        drain();

        // Reset mid-sequence drops tracking.
        cyc(mk(1, 0, 3, 1, 2, 2'b11), 1'b0, 1'b0);
        cyc(mk(1, 0, 4, 3, 0, 2'b01), 1'b0, 1'b0);
        cyc(nop_i, 1'b0, 1'b1);
        chk("pre_rst_fwd", obs_sel_a[1:0], 1);
        cyc(nop_i, 1'b0, 1'b0);
        chk("post_rst_sel_a", obs_sel_a, 0);
        chk("post_rst_sel_b", obs_sel_b, 0);
        chk("post_rst_ex", obs_ex_a, 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++)
            cyc(rnd_ins(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
